logic_unit_arbiter: RTL and testbench

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

---
 rtl/lu_pkg.sv | 19 +
 rtl/lu_core.sv | 29 ++
 rtl/logic_unit_arbiter.sv | 107 ++++++++++
 tb/tb_logic_unit_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lu_pkg.sv
// Shared op-code constants and FSM state encoding for the arbitrated logic unit.
package lu_pkg;

  localparam logic [2:0] OP_AND     = 3'd0;
  localparam logic [2:0] OP_OR      = 3'd1;
  localparam logic [2:0] OP_NOT     = 3'd2;
  localparam logic [2:0] OP_NAND    = 3'd3;
  localparam logic [2:0] OP_NOR     = 3'd4;
  localparam logic [2:0] OP_XOR     = 3'd5;
  localparam logic [2:0] OP_XNOR    = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/lu_core.sv
// Purely combinational bitwise operation unit; op 7 yields zero with err set.
module lu_core
  import lu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for lu_core: IDLE grants, EXEC computes,
// RESP holds the result until the downstream handshake.
module logic_unit_arbiter
  import lu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             res_err,
  output logic             busy
);

  state_t           state;
  logic             prio;
  logic [1:0]       grant;
  logic             win;
  logic [2:0]       op_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             id_p0;
  logic [WIDTH-1:0] y;
  logic             err;

  // Grant is combinational so the winner sees ready in the same IDLE cycle.
  always_comb begin
    grant = 2'b00;
    win   = prio;
    if (state == IDLE) begin
      case (req_valid)
        2'b01: begin win = 1'b0; grant = 2'b01; end
        2'b10: begin win = 1'b1; grant = 2'b10; end
        2'b11: begin win = prio; grant = prio ? 2'b10 : 2'b01; end
        default: ;
      endcase
    end
  end

  assign req_ready = grant;
  assign busy      = (state != IDLE);

  // Stage p0: operand capture on the accept edge; held through EXEC.
  always_ff @(posedge clk) begin
    if (|grant) begin
      op_p0 <= win ? req_op1 : req_op0;
      a_p0  <= win ? req_a1  : req_a0;
      b_p0  <= win ? req_b1  : req_b0;
      id_p0 <= win;
    end
  end

  lu_core #(.WIDTH(WIDTH)) u_core (
    .op  (op_p0),
    .a   (a_p0),
    .b   (b_p0),
    .y   (y),
    .err (err)
  );

  // Stage p1: result registers, loaded in EXEC and held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            prio  <= ~win;
            state <= EXEC;
          end
        end
        EXEC: begin
          res_data  <= y;
          res_err   <= err;
          res_id    <= id_p0;
          res_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed and randomized bench for logic_unit_arbiter against a transaction-level model.
module tb_logic_unit_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [2:0] req_op0 = '0, req_op1 = '0;
  logic [7:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_id;
  logic       res_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Reference model state: one outstanding transaction at most.
  bit         m_pending = 0;
  int         m_age = 0;
  bit         m_prio = 0;
  logic [7:0] m_data = '0;
  bit         m_id = 0;
  bit         m_err = 0;

  logic       obs_valid;
  logic [7:0] obs_data;
  logic       obs_id;
  logic       obs_err;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_err   (res_err),
    .busy      (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~a;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return a ^ b;
      3'd6: return ~(a ^ b);
      default: return 8'h00;
    endcase
  endfunction

  // One cycle: drive at negedge, check settled outputs, then advance the model over the posedge.
  task automatic step(input logic [1:0] v, input logic [2:0] o0, input logic [7:0] a0, input logic [7:0] b0,
                      input logic [2:0] o1, input logic [7:0] a1, input logic [7:0] b1, input logic rr);
    logic [1:0] exp_ready;
    bit         exp_valid;
    bit         w;
    @(negedge clk);
    req_valid = v; req_op0 = o0; req_a0 = a0; req_b0 = b0;
    req_op1 = o1; req_a1 = a1; req_b1 = b1; res_ready = rr;
    #1;
    exp_valid = m_pending && (m_age >= 1);
    if (m_pending) exp_ready = 2'b00;
    else if (v == 2'b11) exp_ready = m_prio ? 2'b10 : 2'b01;
    else exp_ready = v;
    check_val("req_ready", 32'(req_ready), 32'(exp_ready));
    check_val("busy", 32'(busy), 32'(m_pending));
    check_val("res_valid", 32'(res_valid), 32'(exp_valid));
    if (exp_valid) begin
      check_val("res_data", 32'(res_data), 32'(m_data));
      check_val("res_id", 32'(res_id), 32'(m_id));
      check_val("res_err", 32'(res_err), 32'(m_err));
    end
    obs_valid = res_valid; obs_data = res_data; obs_id = res_id; obs_err = res_err;
    if (exp_valid && rr) begin
      m_pending = 0;
    end else if (m_pending) begin
      m_age++;
    end else if (exp_ready != 2'b00) begin
      w = exp_ready[1];
      m_data = w ? ref_op(o1, a1, b1) : ref_op(o0, a0, b0);
      m_err  = w ? (o1 == 3'd7) : (o0 == 3'd7);
      m_id   = w;
      m_prio = !w;
      m_pending = 1;
      m_age = 0;
    end
  endtask

  task automatic idle_step(input logic rr);
    step(2'b00, 3'd0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00, rr);
  endtask

  task automatic drain();
    for (int i = 0; i < 6 && m_pending; i++) idle_step(1'b1);
    check_val("drain_timeout", 32'(m_pending), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_valid"}, 32'(res_valid), 32'd0);
    check_val({tag, "_data"}, 32'(res_data), 32'd0);
    check_val({tag, "_id"}, 32'(res_id), 32'd0);
    check_val({tag, "_err"}, 32'(res_err), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] sweep_exp [7];
    int         ids [$];
    logic [7:0] held;

    sweep_exp = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55};

    #12;
    check_zero_outputs("rst");
    check_val("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Single request from requester 0, latency check.
    step(2'b01, 3'd0, 8'hF0, 8'h3C, 3'd0, 8'h00, 8'h00, 1'b0);
    idle_step(1'b0);
    check_val("single_lat1", 32'(obs_valid), 32'd0);
    idle_step(1'b1);
    check_val("single_valid", 32'(obs_valid), 32'd1);
    check_val("single_data", 32'(obs_data), 32'h30);
    check_val("single_id", 32'(obs_id), 32'd0);
    check_val("single_err", 32'(obs_err), 32'd0);

    // Op sweep on requester 0.
    for (int op = 0; op < 7; op++) begin
      step(2'b01, 3'(op), 8'hA5, 8'h0F, 3'd0, 8'h00, 8'h00, 1'b1);
      idle_step(1'b1);
      idle_step(1'b1);
      check_val($sformatf("sweep_op%0d", op), 32'(obs_data), 32'(sweep_exp[op]));
    end

    // Illegal op from requester 1; leaves priority with requester 0.
    step(2'b10, 3'd0, 8'h00, 8'h00, 3'd7, 8'hFF, 8'h12, 1'b1);
    idle_step(1'b1);
    idle_step(1'b1);
    check_val("illegal_data", 32'(obs_data), 32'h00);
    check_val("illegal_err", 32'(obs_err), 32'd1);
    check_val("illegal_id", 32'(obs_id), 32'd1);

    // Continuous contention.
    for (int i = 0; i < 12; i++) begin
      step(2'b11, 3'd5, 8'(i), 8'h3C, 3'd1, 8'(i * 3), 8'h81, 1'b1);
      if (obs_valid) ids.push_back(int'(obs_id));
    end
    check_val("cont_count", 32'(ids.size()), 32'd4);
    for (int i = 0; i < 4 && i < ids.size(); i++)
      check_val($sformatf("cont_id%0d", i), 32'(ids[i]), 32'(i % 2));
    drain();

    // Backpressure: result held for 5 cycles.
    step(2'b01, 3'd6, 8'h3C, 8'h0F, 3'd0, 8'h00, 8'h00, 1'b0);
    idle_step(1'b0);
    idle_step(1'b0);
    held = obs_data;
    for (int i = 0; i < 5; i++) begin
      step(2'b11, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
           3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b0);
      check_val("bp_ready", 32'(req_ready), 32'd0);
      check_val("bp_stable", 32'(obs_data), 32'(held));
      check_val("bp_valid", 32'(obs_valid), 32'd1);
    end
    idle_step(1'b1);
    idle_step(1'b0);
    check_val("bp_back_idle", 32'(busy), 32'd0);

    // Reset during EXEC: an op is accepted, then reset lands one cycle later.
    step(2'b10, 3'd1, 8'h00, 8'h00, 3'd1, 8'hC3, 8'h18, 1'b1);
    step(2'b10, 3'd1, 8'h00, 8'h00, 3'd1, 8'hC3, 8'h18, 1'b1);
    idle_step(1'b1);
    idle_step(1'b1);
    step(2'b10, 3'd1, 8'h00, 8'h00, 3'd1, 8'h5A, 8'h81, 1'b0);
    @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    m_pending = 0; m_prio = 0; m_age = 0;
    idle_step(1'b1);
    check_val("midrst_stale", 32'(obs_valid), 32'd0);
    step(2'b11, 3'd0, 8'hFF, 8'h0F, 3'd0, 8'hFF, 8'hF0, 1'b1);
    check_val("midrst_grant0", 32'(req_ready), 32'd1);
    drain();

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      step(2'($urandom), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
           3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
